// File: rtl/pipe_stage_buf.sv
// Handshaked two-entry skid buffer between the fetch and decode stages.
// Carries PC/instruction pairs in FIFO order, with flush and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned               PC_W    = 32,
  parameter int unsigned               INS_W   = 32,
  parameter logic [INS_W-1:0]          NOP_INS = INS_W'(0),
  parameter int unsigned               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [INS_W-1:0] in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_ins,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  main_pc;
  logic [INS_W-1:0] main_ins;
  logic [PC_W-1:0]  skid_pc;
  logic [INS_W-1:0] skid_ins;
  logic             accept;
  logic             pop;

  // Handshake flags depend only on the registered occupancy, never on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_pc    = out_valid ? main_pc  : PC_W'(0);
  assign out_ins   = out_valid ? main_ins : NOP_INS;

  // Occupancy and storage; flush only resets occupancy, data may stay stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      main_pc  <= PC_W'(0);
      main_ins <= INS_W'(0);
      skid_pc  <= PC_W'(0);
      skid_ins <= INS_W'(0);
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_pc  <= in_pc;
            main_ins <= in_ins;
            state    <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_pc  <= in_pc;
            main_ins <= in_ins;
          end else if (accept) begin
            skid_pc  <= in_pc;
            skid_ins <= in_ins;
            state    <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_pc  <= skid_pc;
            main_ins <= skid_ins;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Stall cycles seen by the downstream stage; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= CNT_W'(0);
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
